// File: rtl/ps2_keys_pkg.sv
// rtl/ps2_keys_pkg.sv - shared constants for the PS/2 key receiver and decoder
package ps2_keys_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam logic [7:0] DEF_KEY0_CODE = 8'h1C;
    localparam logic [7:0] DEF_KEY1_CODE = 8'h1B;
    localparam logic [7:0] DEF_KEY2_CODE = 8'h23;
    localparam logic [7:0] DEF_KEY3_CODE = 8'h2B;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronizer, bit FSM and inter-edge timeout
module ps2_rx
    import ps2_keys_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_error,
    output logic       accept,
    output logic [7:0] accept_byte
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_CYCLES);

    logic          r_clk_meta, r_clk_sync, r_clk_prev;
    logic          r_dat_meta, r_dat_sync;
    logic [1:0]    r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_parity;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_code;
    logic          r_code_valid;
    logic          r_frame_error;

    logic w_fall;
    logic w_timeout;
    logic w_accept;

    // Idle level is high, so resetting to 1 keeps reset release edge-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_accept  = w_fall && (r_state == ST_STOP) && r_dat_sync
                       && odd_parity_ok(r_shift, r_parity);
    assign w_timeout = !w_fall && (r_state != ST_IDLE) && (r_tcnt == T_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_shift       <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_parity      <= 1'b0;
            r_tcnt        <= '0;
            r_code        <= 8'h00;
            r_code_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_code_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_fall) begin
                r_tcnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_sync) begin
                            r_state   <= ST_DATA;
                            r_shift   <= 8'h00;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {r_dat_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= r_dat_sync;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (w_accept) begin
                            r_code       <= r_shift;
                            r_code_valid <= 1'b1;
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                r_frame_error <= 1'b1;
                r_state       <= ST_IDLE;
                r_shift       <= 8'h00;
                r_bit_cnt     <= 3'd0;
                r_tcnt        <= '0;
            end else if (r_state == ST_IDLE) begin
                r_tcnt <= '0;
            end else if (r_tcnt != T_SAT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    assign code        = r_code;
    assign code_valid  = r_code_valid;
    assign frame_error = r_frame_error;
    // Pre-register view lets the decoder update keys alongside code_valid.
    assign accept      = w_accept;
    assign accept_byte = r_shift;

endmodule

// File: rtl/ps2_keys.sv
// rtl/ps2_keys.sv - PS/2 keyboard to 4-key level map with break/extended prefix handling
module ps2_keys
    import ps2_keys_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] KEY0_CODE      = DEF_KEY0_CODE,
    parameter logic [7:0] KEY1_CODE      = DEF_KEY1_CODE,
    parameter logic [7:0] KEY2_CODE      = DEF_KEY2_CODE,
    parameter logic [7:0] KEY3_CODE      = DEF_KEY3_CODE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [3:0] keys,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_error
);

    logic       w_accept;
    logic [7:0] w_byte;
    logic [3:0] w_hit;
    logic       r_break_pend;
    logic       r_ext_pend;
    logic [3:0] r_keys;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .code       (code),
        .code_valid (code_valid),
        .frame_error(frame_error),
        .accept     (w_accept),
        .accept_byte(w_byte)
    );

    assign w_hit = {w_byte == KEY3_CODE, w_byte == KEY2_CODE,
                    w_byte == KEY1_CODE, w_byte == KEY0_CODE};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_break_pend <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_keys       <= 4'b0000;
        end else if (w_accept) begin
            if (w_byte == BREAK_CODE) begin
                r_break_pend <= 1'b1;
            end else if (w_byte == EXT_CODE) begin
                r_ext_pend <= 1'b1;
            end else begin
                // Extended-prefixed codes share make codes with the main block; ignore them.
                if (!r_ext_pend) begin
                    r_keys <= (r_keys & ~w_hit) | (w_hit & {4{~r_break_pend}});
                end
                r_break_pend <= 1'b0;
                r_ext_pend   <= 1'b0;
            end
        end
    end

    assign keys = r_keys;

endmodule
